// File: rtl/pwm_sd_feeder_if.sv
// PCM sample bus from the FM core into the DAC feeder: one-cycle valid strobe, no ready.
// The feeder always accepts, so a sample that arrives before the previous one is used overwrites it.
interface pwm_sd_feeder_if;
    logic [15:0] din_l;
    logic [15:0] din_r;
    logic        din_valid;

    modport master (output din_l, din_r, din_valid);
    modport slave  (input  din_l, din_r, din_valid);
endinterface

// File: rtl/pwm_sd_feeder.sv
// Stereo PWM/sigma-delta DAC feeder: double-buffers signed PCM, gain-ramps it and updates dout at frame edges.
// Latency din_valid->dout <= one frame + 1 clk; no backpressure, a late-consumed sample is overwritten (overrun).
module pwm_sd_feeder #(
    parameter int FRAME_BITS = 5,
    parameter int GAIN_BITS  = 8,
    parameter int RAMP_DIV   = 4
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            en,
    pwm_sd_feeder_if.slave  pcm,
    input  logic            clr_status,
    output logic [15:0]     dout_l,
    output logic [15:0]     dout_r,
    output logic            frame_tick,
    output logic [1:0]      state,
    output logic            overrun,
    output logic            underrun
);
    typedef enum logic [1:0] {
        MUTE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam int PW = 17 + GAIN_BITS;
    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [GAIN_BITS:0]    G_MAX    = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GAIN_BITS:0]    G_ZERO   = '0;
    localparam logic [GAIN_BITS:0]    G_ONE    = (GAIN_BITS+1)'(1);
    localparam logic [DW-1:0]         DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]         DIV_ONE  = DW'(1);
    localparam logic [FRAME_BITS-1:0] CNT_ONE  = FRAME_BITS'(1);

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [GAIN_BITS:0] g);
        logic signed [PW-1:0] s_ext;
        logic signed [PW-1:0] g_ext;
        logic signed [PW-1:0] prod;
        s_ext = {{(PW-16){s[15]}}, s};
        g_ext = {{(PW-GAIN_BITS-1){1'b0}}, g};
        prod  = s_ext * g_ext;
        scale = 16'(prod >>> GAIN_BITS) ^ 16'h8000;
    endfunction

    logic [FRAME_BITS-1:0] cnt_q;
    logic                  pend_vld;
    logic [15:0]           pend_l, pend_r;
    logic [15:0]           last_l, last_r;
    logic [15:0]           src_l, src_r;
    logic [GAIN_BITS:0]    g_q, g_d;
    logic [DW-1:0]         div_q, div_d;
    logic                  step;
    logic                  ovr_set, unr_set;
    state_t                st_q, st_d;

    assign frame_tick = &cnt_q;
    assign step       = (div_q == DIV_LAST);
    // With nothing pending the previous sample is replayed at the new gain.
    assign src_l      = pend_vld ? pend_l : last_l;
    assign src_r      = pend_vld ? pend_r : last_r;
    // A sample landing on the tick cycle replaces one that is being consumed, so it is not an overrun.
    assign ovr_set    = pcm.din_valid && pend_vld && !frame_tick;
    assign unr_set    = frame_tick && !pend_vld && (st_q == RUN);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q    <= '0;
            pend_vld <= 1'b0;
            pend_l   <= '0;
            pend_r   <= '0;
            last_l   <= '0;
            last_r   <= '0;
            dout_l   <= 16'h8000;
            dout_r   <= 16'h8000;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (pcm.din_valid) begin
                pend_vld <= 1'b1;
                pend_l   <= pcm.din_l;
                pend_r   <= pcm.din_r;
            end else if (frame_tick) begin
                pend_vld <= 1'b0;
            end
            if (frame_tick) begin
                last_l <= src_l;
                last_r <= src_r;
                dout_l <= scale(src_l, g_q);
                dout_r <= scale(src_r, g_q);
            end
            if (ovr_set)         overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
            if (unr_set)         underrun <= 1'b1;
            else if (clr_status) underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) st_q <= MUTE;
        else          st_q <= st_d;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            g_q   <= '0;
            div_q <= '0;
        end else begin
            g_q   <= g_d;
            div_q <= div_d;
        end
    end

    // Ramp entry from the opposite direction can see g already at the end stop; the
    // end-stop checks keep g inside 0..G_MAX in that case.
    always_comb begin
        st_d = st_q;
        if (frame_tick) begin
            unique case (st_q)
                MUTE:      if (en) st_d = RAMP_UP;
                RAMP_UP:   if (!en) st_d = RAMP_DOWN;
                           else if (g_q == G_MAX || (step && g_q == G_MAX - G_ONE)) st_d = RUN;
                RUN:       if (!en) st_d = RAMP_DOWN;
                RAMP_DOWN: if (en) st_d = RAMP_UP;
                           else if (g_q == G_ZERO || (step && g_q == G_ONE)) st_d = MUTE;
                default:   st_d = MUTE;
            endcase
        end
    end

    always_comb begin
        g_d   = g_q;
        div_d = div_q;
        state = st_q;
        if (frame_tick) begin
            unique case (st_q)
                MUTE: begin
                    g_d   = G_ZERO;
                    div_d = '0;
                end
                RAMP_UP: begin
                    if (!en || g_q == G_MAX) div_d = '0;
                    else if (step) begin
                        g_d   = g_q + G_ONE;
                        div_d = '0;
                    end else div_d = div_q + DIV_ONE;
                end
                RUN: begin
                    g_d   = G_MAX;
                    div_d = '0;
                end
                RAMP_DOWN: begin
                    if (en || g_q == G_ZERO) div_d = '0;
                    else if (step) begin
                        g_d   = g_q - G_ONE;
                        div_d = '0;
                    end else div_d = div_q + DIV_ONE;
                end
                default: begin
                    g_d   = G_ZERO;
                    div_d = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_sd_feeder.sv
// Bench for pwm_sd_feeder: directed phases with random sample data/timing, compared every cycle
// against a frame-level reference model built from plain arithmetic and a pending-sample queue.
module tb_pwm_sd_feeder;
    localparam int FB    = 5;
    localparam int GB    = 8;
    localparam int RD    = 2;
    localparam int FRAME = 1 << FB;
    localparam int GMAX  = 1 << GB;

    logic        clk, n_reset, en, clr_status;
    logic [15:0] dout_l, dout_r;
    logic        frame_tick;
    logic [1:0]  state;
    logic        overrun, underrun;
    int          checks = 0;
    int          errors = 0;

    pwm_sd_feeder_if pcm();

    pwm_sd_feeder #(.FRAME_BITS(FB), .GAIN_BITS(GB), .RAMP_DIV(RD)) dut (
        .clk(clk), .n_reset(n_reset), .en(en), .pcm(pcm), .clr_status(clr_status),
        .dout_l(dout_l), .dout_r(dout_r), .frame_tick(frame_tick), .state(state),
        .overrun(overrun), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed { logic [15:0] l; logic [15:0] r; } smp_t;

    int          m_cnt, m_state, m_g, m_k, m_gused;
    logic [15:0] m_dl, m_dr, m_last_l, m_last_r;
    bit          m_ovr, m_unr;
    smp_t        m_pend[$];

    function automatic logic [15:0] ref_scale(input logic [15:0] s, input int g);
        int p;
        p = $signed(s) * g;
        p = p >>> GB;
        return 16'(p) ^ 16'h8000;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_state = 0; m_g = 0; m_k = 0; m_gused = 0;
        m_dl = 16'h8000; m_dr = 16'h8000; m_last_l = 0; m_last_r = 0;
        m_ovr = 0; m_unr = 0;
        m_pend.delete();
    endtask

    task automatic model_edge();
        bit   b, ovr_ev, unr_ev;
        smp_t s;
        b = (m_cnt == FRAME - 1);
        ovr_ev = 0; unr_ev = 0;
        if (b) begin
            if (m_pend.size() > 0) begin
                s = m_pend.pop_front();
                m_last_l = s.l; m_last_r = s.r;
            end else if (m_state == 2) unr_ev = 1;
            m_dl = ref_scale(m_last_l, m_g);
            m_dr = ref_scale(m_last_r, m_g);
            m_gused = m_g;
        end
        if (pcm.din_valid) begin
            if (m_pend.size() > 0) ovr_ev = 1;
            m_pend.delete();
            m_pend.push_back({pcm.din_l, pcm.din_r});
        end
        if (clr_status) begin m_ovr = 0; m_unr = 0; end
        if (ovr_ev) m_ovr = 1;
        if (unr_ev) m_unr = 1;
        if (b) begin
            case (m_state)
                0: begin m_k = 0; if (en) m_state = 1; end
                1: if (!en) begin m_state = 3; m_k = 0; end
                   else if (m_g == GMAX) begin m_state = 2; m_k = 0; end
                   else begin
                       m_k++;
                       if (m_k == RD) begin m_k = 0; m_g++; if (m_g == GMAX) m_state = 2; end
                   end
                2: begin m_k = 0; if (!en) m_state = 3; end
                default: if (en) begin m_state = 1; m_k = 0; end
                   else if (m_g == 0) begin m_state = 0; m_k = 0; end
                   else begin
                       m_k++;
                       if (m_k == RD) begin m_k = 0; m_g--; if (m_g == 0) m_state = 0; end
                   end
            endcase
        end
        m_cnt = (m_cnt + 1) % FRAME;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("frame_tick", 32'(frame_tick), 32'(m_cnt == FRAME - 1));
        check("dout_l", 32'(dout_l), 32'(m_dl));
        check("dout_r", 32'(dout_r), 32'(m_dr));
        check("state", 32'(state), 32'(m_state));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("underrun", 32'(underrun), 32'(m_unr));
    endtask

    task automatic cycle(input logic v, input logic [15:0] l, input logic [15:0] r, input logic c);
        pcm.din_valid = v; pcm.din_l = l; pcm.din_r = r; clr_status = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic align();
        while (m_cnt != 0) cycle(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic frame(input int p1, input logic [15:0] l1, input logic [15:0] r1,
                         input int p2, input logic [15:0] l2, input logic [15:0] r2, input int pc);
        align();
        for (int i = 0; i < FRAME; i++) begin
            if (i == p1)      cycle(1'b1, l1, r1, 1'(i == pc));
            else if (i == p2) cycle(1'b1, l2, r2, 1'(i == pc));
            else              cycle(1'b0, 16'h0, 16'h0, 1'(i == pc));
        end
    endtask

    initial begin
        int nf;
        int first;
        n_reset = 0; en = 0; clr_status = 0;
        pcm.din_valid = 0; pcm.din_l = 0; pcm.din_r = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        n_reset = 1;

        // Muted: first tick lands on cycle FRAME-1, output stays at mid-scale.
        first = -1;
        for (int i = 0; i < FRAME + 8; i++) begin
            if (frame_tick === 1'b1) begin first = i; break; end
            cycle(1'b0, 16'h0, 16'h0, 1'b0);
        end
        check("first_tick", 32'(first), 32'(FRAME - 1));
        for (int f = 0; f < 3; f++)
            frame($urandom_range(0, FRAME - 1), 16'($urandom), 16'($urandom), -1, 0, 0, -1);

        // Ramp up to RUN with a full-scale left channel.
        align();
        en = 1;
        nf = 0;
        while (m_state != 2 && nf < 700) begin
            frame($urandom_range(0, FRAME - 1), 16'h7FFF, 16'($urandom), -1, 0, 0, -1);
            nf++;
            if (m_gused == 128) check("g128_dout_l", 32'(dout_l), 32'h0000BFFF);
        end
        check("frames_to_run", 32'(nf), 32'(1 + GMAX * RD));
        check("run_state", 32'(state), 32'd2);

        frame($urandom_range(0, FRAME - 2), 16'h8000, 16'h7FFF, -1, 0, 0, -1);
        check("neg_full", 32'(dout_l), 32'h00000000);
        check("pos_full", 32'(dout_r), 32'h0000FFFF);

        align();
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check("clr_ovr", 32'(overrun), 32'd0);
        check("clr_unr", 32'(underrun), 32'd0);

        frame(3, 16'h1111, 16'h1111, 10, 16'h2222, 16'h2222, -1);
        check("second_wins_l", 32'(dout_l), 32'h0000A222);
        check("second_wins_r", 32'(dout_r), 32'h0000A222);
        check("overrun_set", 32'(overrun), 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check("overrun_clr", 32'(overrun), 32'd0);

        frame(2, 16'h1234, 16'h1234, 5, 16'h4321, 16'h4321, 5);
        check("set_beats_clr", 32'(overrun), 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 1'b1);

        frame(-1, 0, 0, -1, 0, 0, -1);
        check("underrun_set", 32'(underrun), 32'd1);
        check("repeat_last", 32'(dout_l), 32'h0000C321);

        // Asynchronous reset in the middle of a frame.
        repeat (7) cycle(1'b0, 16'h0, 16'h0, 1'b0);
        #2 n_reset = 0;
        #1;
        check("rst_dout_l", 32'(dout_l), 32'h00008000);
        check("rst_dout_r", 32'(dout_r), 32'h00008000);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ovr_unr", 32'({overrun, underrun, frame_tick}), 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        n_reset = 1;

        // Ramp up to g=100, then mute and ramp back down.
        en = 1;
        nf = 0;
        while (m_g != 100 && nf < 400) begin
            frame($urandom_range(0, FRAME - 1), 16'($urandom), 16'($urandom), -1, 0, 0, -1);
            nf++;
        end
        en = 0;
        nf = 0;
        while (m_state != 0 && nf < 400) begin
            frame($urandom_range(0, FRAME - 1), 16'($urandom), 16'($urandom), -1, 0, 0, -1);
            nf++;
        end
        check("frames_to_mute", 32'(nf), 32'(1 + 100 * RD));
        frame($urandom_range(0, FRAME - 2), 16'h7FFF, 16'h8000, -1, 0, 0, -1);
        check("mute_l", 32'(dout_l), 32'h00008000);
        check("mute_r", 32'(dout_r), 32'h00008000);

        // Random enable toggling, sample timing and status clears.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) en = ~en;
            frame($urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, FRAME - 1)),
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 2) == 0 ? int'($urandom_range(0, FRAME - 1)) : -1,
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 3) == 0 ? int'($urandom_range(0, FRAME - 1)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
